// File: rtl/alu_pkg.sv
// Shared types for the ALU issue/writeback controller: opcodes, instruction layout, FSM states.
package alu_pkg;

  localparam int REG_W  = 24;
  localparam int REG_AW = 4;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_XOR = 4'd3,
    OP_INV = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_LDI = 4'd7
  } opcode_e;

  // Field order fixes the bit positions: [23:20] opcode, [19:16] rd, [15:12] rsa, [11:8] rsb, [7:0] imm8.
  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rsa;
    logic [3:0] rsb;
    logic [7:0] imm8;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  function automatic logic is_illegal(input logic [3:0] opcode);
    return opcode[3];
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: NREGS x 24, two async read ports, async debug read, one sync write port.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] i_ra_addr,
  input  logic [REG_AW-1:0] i_rb_addr,
  input  logic [REG_AW-1:0] i_dbg_addr,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_wa,
  input  logic [REG_W-1:0]  i_wd,
  output logic [REG_W-1:0]  o_ra_data,
  output logic [REG_W-1:0]  o_rb_data,
  output logic [REG_W-1:0]  o_dbg_data
);

  logic [REG_W-1:0] r_mem [NREGS];

  // NOTE: every entry must clear on reset, so this stays in flops rather than a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_ra_data  = r_mem[i_ra_addr];
  assign o_rb_data  = r_mem[i_rb_addr];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one instruction at a time to an external 24-bit ALU and writes the result back.
// Optional ALU_ISSUE_FLAGS_EN adds registered zero/negative flags updated on each writeback.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int NREGS      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [23:0]       instr,
  output logic              instr_ready,
  output logic [3:0]        alu_opcode,
  output logic [REG_W-1:0]  alu_opA,
  output logic [REG_W-1:0]  alu_opB,
  input  logic [REG_W-1:0]  alu_result,
  output logic              busy,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_addr,
  output logic [REG_W-1:0]  wb_data,
  output logic              err,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [REG_W-1:0]  dbg_data
`ifdef ALU_ISSUE_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_n
`endif
);

  localparam int CNT_W = (MUL_CYCLES > 0) ? $clog2(MUL_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(MUL_CYCLES);

  instr_t             w_instr;
  logic [REG_W-1:0]   w_ra_data;
  logic [REG_W-1:0]   w_rb_data;
  state_e             r_state;
  logic [REG_AW-1:0]  r_rd;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_alu_opcode;
  logic [REG_W-1:0]   r_alu_opA;
  logic [REG_W-1:0]   r_alu_opB;
  logic               r_wb_valid;
  logic [REG_AW-1:0]  r_wb_addr;
  logic [REG_W-1:0]   r_wb_data;
  logic               r_err;

  assign w_instr = instr_t'(instr);

  alu_regfile #(.NREGS(NREGS)) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .i_ra_addr  (w_instr.rsa),
    .i_rb_addr  (w_instr.rsb),
    .i_dbg_addr (dbg_addr),
    .i_we       (r_state == ST_WB),
    .i_wa       (r_wb_addr),
    .i_wd       (r_wb_data),
    .o_ra_data  (w_ra_data),
    .o_rb_data  (w_rb_data),
    .o_dbg_data (dbg_data)
  );

  // NOTE: err and wb_valid default low every cycle so they can only ever be single-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_rd         <= '0;
      r_cnt        <= '0;
      r_alu_opcode <= '0;
      r_alu_opA    <= '0;
      r_alu_opB    <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_addr    <= '0;
      r_wb_data    <= '0;
      r_err        <= 1'b0;
    end else begin
      r_err      <= 1'b0;
      r_wb_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (instr_valid) begin
            if (is_illegal(w_instr.opcode)) begin
              r_err <= 1'b1;
            end else begin
              r_rd         <= w_instr.rd;
              r_alu_opcode <= w_instr.opcode;
              r_alu_opA    <= (w_instr.opcode == OP_LDI) ? {16'd0, w_instr.imm8} : w_ra_data;
              r_alu_opB    <= w_rb_data;
              r_cnt        <= (w_instr.opcode == OP_MUL) ? CNT_MUL : '0;
              r_state      <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          if (r_cnt == '0) begin
            r_state    <= ST_WB;
            r_wb_valid <= 1'b1;
            r_wb_addr  <= r_rd;
            r_wb_data  <= (r_alu_opcode == OP_LDI) ? r_alu_opA : alu_result;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_WB:   r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_ISSUE_FLAGS_EN
  logic r_flag_z;
  logic r_flag_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
    end else if (r_state == ST_WB) begin
      r_flag_z <= (r_wb_data == '0);
      r_flag_n <= r_wb_data[REG_W-1];
    end
  end

  assign flag_z = r_flag_z;
  assign flag_n = r_flag_n;
`endif

  assign instr_ready = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign alu_opcode  = r_alu_opcode;
  assign alu_opA     = r_alu_opA;
  assign alu_opB     = r_alu_opB;
  assign wb_valid    = r_wb_valid;
  assign wb_addr     = r_wb_addr;
  assign wb_data     = r_wb_data;
  assign err         = r_err;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed vector table, random instructions against a register-array model, reset abort.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int MUL_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [23:0] instr;
  logic        instr_ready;
  logic [3:0]  alu_opcode;
  logic [23:0] alu_opA;
  logic [23:0] alu_opB;
  logic [23:0] alu_result;
  logic        busy;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [23:0] wb_data;
  logic        err;
  logic [3:0]  dbg_addr;
  logic [23:0] dbg_data;
`ifdef ALU_ISSUE_FLAGS_EN
  logic        flag_z;
  logic        flag_n;
  logic        exp_fz = 1'b0;
  logic        exp_fn = 1'b0;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [23:0] ref_regs [16];

  always #5 clk = ~clk;

  // External combinational ALU; LDI returns a junk pattern the controller must ignore.
  always_comb begin
    alu_result = 24'd0;
    case (alu_opcode)
      4'd0: alu_result = alu_opA + alu_opB;
      4'd1: alu_result = alu_opA - alu_opB;
      4'd2: alu_result = alu_opA * alu_opB;
      4'd3: alu_result = alu_opA ^ alu_opB;
      4'd4: alu_result = ~alu_opA;
      4'd5: alu_result = alu_opA & alu_opB;
      4'd6: alu_result = alu_opA | alu_opB;
      4'd7: alu_result = 24'hA5A5A5;
      default: alu_result = 24'd0;
    endcase
  end

  alu_issue_ctrl #(.MUL_CYCLES(MUL_CYCLES), .NREGS(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_opcode  (alu_opcode),
    .alu_opA     (alu_opA),
    .alu_opB     (alu_opB),
    .alu_result  (alu_result),
    .busy        (busy),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .err         (err),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
`ifdef ALU_ISSUE_FLAGS_EN
    ,
    .flag_z      (flag_z),
    .flag_n      (flag_n)
`endif
  );

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Architectural meaning of each opcode, independent of how the controller sequences it.
  function automatic logic [23:0] ref_exec(input logic [3:0] op, input logic [23:0] a,
                                           input logic [23:0] b, input logic [7:0] imm);
    logic [47:0] prod;
    prod = {24'd0, a} * {24'd0, b};
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return prod[23:0];
      4'd3: return a ^ b;
      4'd4: return ~a;
      4'd5: return a & b;
      4'd6: return a | b;
      4'd7: return {16'd0, imm};
      default: return 24'd0;
    endcase
  endfunction

  // Issue one instruction at a negedge and follow it to writeback (or to the err pulse).
  task automatic run_instr(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rsa,
                           input logic [3:0] rsb, input logic [7:0] imm,
                           input logic [23:0] exp_data, input string tag);
    int k;
    int exp_lat;
    logic [23:0] old_rd;
    check({tag, ".ready_before"}, 24'(instr_ready), 24'd1);
    instr       = {op, rd, rsa, rsb, imm};
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = 24'($urandom);
    if (op[3]) begin
      check({tag, ".err_pulse"}, 24'(err), 24'd1);
      check({tag, ".ready_after_err"}, 24'(instr_ready), 24'd1);
      check({tag, ".no_wb"}, 24'(wb_valid), 24'd0);
      @(negedge clk);
      check({tag, ".err_drop"}, 24'(err), 24'd0);
      check({tag, ".no_wb_later"}, 24'(wb_valid), 24'd0);
`ifdef ALU_ISSUE_FLAGS_EN
      check({tag, ".flag_z_hold"}, 24'(flag_z), 24'(exp_fz));
      check({tag, ".flag_n_hold"}, 24'(flag_n), 24'(exp_fn));
`endif
      return;
    end
    check({tag, ".exec_opcode"}, 24'(alu_opcode), 24'(op));
    check({tag, ".exec_opA"}, alu_opA, (op == 4'd7) ? {16'd0, imm} : ref_regs[rsa]);
    check({tag, ".exec_opB"}, alu_opB, ref_regs[rsb]);
    check({tag, ".busy_exec"}, 24'(busy), 24'd1);
    exp_lat = (op == 4'd2) ? 1 + MUL_CYCLES : 1;
    k = 0;
    while (!wb_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, ".latency"}, 24'(k), 24'(exp_lat));
    if (!wb_valid) return;
    old_rd   = ref_regs[rd];
    dbg_addr = rd;
    #1;
    check({tag, ".wb_addr"}, 24'(wb_addr), 24'(rd));
    check({tag, ".wb_data"}, wb_data, exp_data);
    check({tag, ".dbg_old"}, dbg_data, old_rd);
    check({tag, ".ready_wb"}, 24'(instr_ready), 24'd0);
    @(negedge clk);
    ref_regs[rd] = exp_data;
    check({tag, ".wb_pulse_end"}, 24'(wb_valid), 24'd0);
    check({tag, ".ready_next"}, 24'(instr_ready), 24'd1);
    check({tag, ".dbg_new"}, dbg_data, exp_data);
`ifdef ALU_ISSUE_FLAGS_EN
    exp_fz = (exp_data == 24'd0);
    exp_fn = exp_data[23];
    check({tag, ".flag_z"}, 24'(flag_z), 24'(exp_fz));
    check({tag, ".flag_n"}, 24'(flag_n), 24'(exp_fn));
`endif
  endtask

  task automatic sweep_regs(input string tag);
    for (int r = 0; r < 16; r++) begin
      dbg_addr = 4'(r);
      #1;
      check($sformatf("%s.r%0d", tag, r), dbg_data, ref_regs[r]);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rsa;
    logic [3:0]  rsb;
    logic [7:0]  imm;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{4'd7, 4'd1, 4'd0, 4'd0, 8'h05, 24'h000005}; // LDI r1,5
    vecs[1] = '{4'd7, 4'd2, 4'd0, 4'd0, 8'h03, 24'h000003}; // LDI r2,3
    vecs[2] = '{4'd0, 4'd3, 4'd1, 4'd2, 8'h00, 24'h000008}; // ADD r3,r1,r2
    vecs[3] = '{4'd2, 4'd4, 4'd1, 4'd2, 8'h00, 24'h00000F}; // MUL r4,r1,r2
    vecs[4] = '{4'd1, 4'd5, 4'd2, 4'd1, 8'h00, 24'hFFFFFE}; // SUB r5,r2,r1
    vecs[5] = '{4'd1, 4'd6, 4'd1, 4'd1, 8'h00, 24'h000000}; // SUB r6,r1,r1
    vecs[6] = '{4'd0, 4'd2, 4'd2, 4'd2, 8'h00, 24'h000006}; // ADD r2,r2,r2 reads pre-write r2
    vecs[7] = '{4'd7, 4'd8, 4'd0, 4'd0, 8'hFF, 24'h0000FF}; // LDI zero-extends
    vecs[8] = '{4'd4, 4'd9, 4'd8, 4'd0, 8'h00, 24'hFFFF00}; // INV r9,r8

    for (int r = 0; r < 16; r++) ref_regs[r] = 24'd0;
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 24'd0;
    dbg_addr    = 4'd0;
    repeat (2) @(negedge clk);

    check("rst.ready", 24'(instr_ready), 24'd1);
    check("rst.busy", 24'(busy), 24'd0);
    check("rst.wb_valid", 24'(wb_valid), 24'd0);
    check("rst.err", 24'(err), 24'd0);
    check("rst.alu_opA", alu_opA, 24'd0);
    check("rst.wb_data", wb_data, 24'd0);
    rst = 1'b0;
    @(negedge clk);
    sweep_regs("rst");

    for (int i = 0; i < 9; i++)
      run_instr(vecs[i].op, vecs[i].rd, vecs[i].rsa, vecs[i].rsb, vecs[i].imm, vecs[i].exp,
                $sformatf("vec%0d", i));

    // Illegal opcode targeting a live register leaves it untouched.
    run_instr(4'hA, 4'd3, 4'd1, 4'd2, 8'h00, 24'd0, "illegal");
    dbg_addr = 4'd3;
    #1;
    check("illegal.r3_kept", dbg_data, 24'h000008);

    for (int i = 0; i < 80; i++) begin
      logic [3:0] op, rd, rsa, rsb;
      logic [7:0] imm;
      op  = ($urandom_range(0, 9) > 7) ? 4'(8 + $urandom_range(0, 7)) : 4'($urandom_range(0, 7));
      rd  = 4'($urandom);
      rsa = 4'($urandom);
      rsb = 4'($urandom);
      imm = 8'($urandom);
      run_instr(op, rd, rsa, rsb, imm, ref_exec(op, ref_regs[rsa], ref_regs[rsb], imm),
                $sformatf("rnd%0d", i));
    end
    sweep_regs("post_rnd");

    // Reset during EXEC of ADD r7 aborts the instruction and clears the file.
    begin
      int wb_seen;
      wb_seen     = 0;
      instr       = {4'd0, 4'd7, 4'd1, 4'd2, 8'h00};
      instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      check("abort.in_exec", 24'(busy), 24'd1);
      rst = 1'b1;
      #1;
      check("abort.idle_now", 24'(instr_ready), 24'd1);
      check("abort.wb_low", 24'(wb_valid), 24'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
        if (wb_valid) wb_seen++;
        @(negedge clk);
      end
      check("abort.no_wb", 24'(wb_seen), 24'd0);
      for (int r = 0; r < 16; r++) ref_regs[r] = 24'd0;
      sweep_regs("abort");
`ifdef ALU_ISSUE_FLAGS_EN
      exp_fz = 1'b0;
      exp_fn = 1'b0;
      check("abort.flag_z", 24'(flag_z), 24'd0);
      check("abort.flag_n", 24'(flag_n), 24'd0);
`endif
    end

    run_instr(4'd7, 4'd7, 4'd0, 4'd0, 8'h42, 24'h000042, "recover");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
